// File: rtl/dram_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : dram_burst_master_if
//  Purpose  : Command, read-stream, write-stream and single-cycle DRAM
//             access signals of the DRAM burst master, grouped into one bundle.
//             master = burst master view, slave = datapath + DRAM view.
//  Revision : 1.0  initial release
// ============================================================================
interface dram_burst_master_if #(
  parameter int COL_NUM  = 128,
  parameter int ADDR_LEN = 25,
  parameter int LEN_W    = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_wr;
  logic [ADDR_LEN-1:0] cmd_addr;
  logic [LEN_W-1:0]    cmd_len;
  logic                rd_valid;
  logic                rd_ready;
  logic [COL_NUM-1:0]  rd_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [COL_NUM-1:0]  wr_data;
  logic                done;
  logic                DRAM_valid;
  logic                DRAM_wr_en;
  logic [ADDR_LEN-1:0] DRAM_addr;
  logic [COL_NUM-1:0]  DRAM_rd_data;
  logic [COL_NUM-1:0]  DRAM_wr_data;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, rd_ready, wr_valid, wr_data, DRAM_rd_data,
    output cmd_ready, rd_valid, rd_data, wr_ready, done,
           DRAM_valid, DRAM_wr_en, DRAM_addr, DRAM_wr_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, rd_ready, wr_valid, wr_data, DRAM_rd_data,
    input  cmd_ready, rd_valid, rd_data, wr_ready, done,
           DRAM_valid, DRAM_wr_en, DRAM_addr, DRAM_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/dram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : dram_burst_master
//  Purpose  : Accepts one burst command, issues one DRAM line access per cycle
//             with an incrementing (wrapping) address and streams lines to /
//             from the compute side. Reads go through a 2-entry FIFO so the
//             consumer can stall without losing the combinational DRAM data.
//  Options  : DRAM_ACC_CNT_EN adds acc_cnt_o, a free-running count of DRAM
//             access cycles (cleared only by rst).
//  Revision : 1.0  initial release
// ============================================================================
module dram_burst_master #(
  parameter int COL_NUM  = 128,
  parameter int ADDR_LEN = 25,
  parameter int LEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  dram_burst_master_if.master bus
`ifdef DRAM_ACC_CNT_EN
  ,
  output logic [31:0]         acc_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;

  logic [COL_NUM-1:0]  fifo_q [2];
  logic                head_q, tail_q;
  logic [1:0]          cnt_q;

  logic                rd_issue;
  logic                wr_issue;
  logic                issue;
  logic                pop;

  // The consumer may only pop what is actually held in the read FIFO.
  assign pop = (cnt_q != 2'd0) && bus.rd_ready;

  // Next-state, address/count bookkeeping and access issue decision.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          rem_d  = bus.cmd_len;
          if (bus.cmd_len == '0)  state_d = S_DONE;
          else if (bus.cmd_wr)    state_d = S_WR;
          else                    state_d = S_RD;
        end
      end
      S_RD: begin
        // A slot frees up this cycle if the head is being popped.
        rd_issue = (rem_q != '0) && ((cnt_q != 2'd2) || pop);
        if ((rem_q == '0) && (cnt_q == 2'd0)) state_d = S_DONE;
      end
      S_WR: begin
        wr_issue = bus.wr_valid;
        if (bus.wr_valid && (rem_q == LEN_W'(1))) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    issue = rd_issue | wr_issue;
    if (issue) begin
      addr_d = addr_q + ADDR_LEN'(1);
      rem_d  = rem_q - LEN_W'(1);
    end
  end

  // State, address and remaining-line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Read FIFO: captures DRAM data at the strobe edge, drained by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (rd_issue) begin
        fifo_q[tail_q] <= bus.DRAM_rd_data;
        tail_q         <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      cnt_q <= cnt_q + {1'b0, rd_issue} - {1'b0, pop};
    end
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.rd_valid     = (cnt_q != 2'd0);
  assign bus.rd_data      = fifo_q[head_q];
  assign bus.wr_ready     = (state_q == S_WR);
  assign bus.done         = (state_q == S_DONE);
  assign bus.DRAM_valid   = issue;
  assign bus.DRAM_wr_en   = (state_q == S_WR);
  assign bus.DRAM_addr    = issue ? addr_q : '0;
  assign bus.DRAM_wr_data = (state_q == S_WR) ? bus.wr_data : '0;

`ifdef DRAM_ACC_CNT_EN
  logic [31:0] acc_cnt_q;

  // Counts every cycle carrying a DRAM access, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst)        acc_cnt_q <= '0;
    else if (issue) acc_cnt_q <= acc_cnt_q + 32'd1;
  end

  assign acc_cnt_o = acc_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_burst_master
//  Purpose  : Self-checking bench for dram_burst_master: directed bursts from
//             the block description plus randomized bursts, checked against a
//             shadow memory and per-burst expected access lists.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_burst_master;
  localparam int COL_NUM  = 128;
  localparam int ADDR_LEN = 25;
  localparam int LEN_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_burst_master_if #(.COL_NUM(COL_NUM), .ADDR_LEN(ADDR_LEN), .LEN_W(LEN_W)) bus ();
`ifdef DRAM_ACC_CNT_EN
  logic [31:0] acc_cnt;
`endif

  dram_burst_master #(.COL_NUM(COL_NUM), .ADDR_LEN(ADDR_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master)
`ifdef DRAM_ACC_CNT_EN
    ,
    .acc_cnt_o (acc_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [COL_NUM-1:0] obs, input logic [COL_NUM-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DRAM model: unwritten line i holds value i; reads are combinational.
  logic [COL_NUM-1:0] dram [logic [ADDR_LEN-1:0]];
  logic [COL_NUM-1:0] ref_mem [logic [ADDR_LEN-1:0]];
  int mem_gen = 0;

  function automatic logic [COL_NUM-1:0] dram_rd(input logic [ADDR_LEN-1:0] a);
    if (dram.exists(a)) return dram[a];
    return COL_NUM'(a);
  endfunction

  function automatic logic [COL_NUM-1:0] ref_rd(input logic [ADDR_LEN-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return COL_NUM'(a);
  endfunction

  always @(bus.DRAM_addr or mem_gen or clk) bus.DRAM_rd_data = dram_rd(bus.DRAM_addr);

  always @(posedge clk) begin
    if (bus.DRAM_valid && bus.DRAM_wr_en) begin
      dram[bus.DRAM_addr] = bus.DRAM_wr_data;
      mem_gen++;
    end
  end

  // Monitor: records accesses and popped lines, tracks expected FIFO occupancy.
  logic [ADDR_LEN-1:0] acc_addr_q [$];
  logic                acc_wr_q   [$];
  logic [COL_NUM-1:0]  acc_data_q [$];
  int                  acc_cyc_q  [$];
  logic [COL_NUM-1:0]  pop_q      [$];
  int  done_cnt = 0;
  int  occ      = 0;
  int  tot      = 0;
  int  cyc      = 0;
  bit  s_rd_issue, s_pop, s_issue;
  bit  beat_drv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    s_rd_issue = 1'b0;
    s_pop      = 1'b0;
    s_issue    = 1'b0;
    if (!rst) begin
      chk("rd_valid_vs_occupancy", bus.rd_valid, occ != 0);
      if (bus.DRAM_valid) begin
        acc_addr_q.push_back(bus.DRAM_addr);
        acc_wr_q.push_back(bus.DRAM_wr_en);
        acc_data_q.push_back(bus.DRAM_wr_data);
        acc_cyc_q.push_back(cyc);
        s_issue    = 1'b1;
        s_rd_issue = !bus.DRAM_wr_en;
      end else begin
        chk("addr_zero_when_idle", bus.DRAM_addr, '0);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        pop_q.push_back(bus.rd_data);
        s_pop = 1'b1;
      end
      if (s_rd_issue) chk("fifo_room", (occ + 1 - int'(s_pop)) <= 2, 1'b1);
      if (!bus.wr_ready) begin
        chk("wr_data_zero_outside_wr", bus.DRAM_wr_data, '0);
        chk("wr_en_low_outside_wr", bus.DRAM_wr_en, 1'b0);
      end
      if (beat_drv) chk("wr_ready_on_beat", bus.wr_ready, 1'b1);
      if (bus.done) begin
        done_cnt++;
        chk("cmd_ready_low_in_done", bus.cmd_ready, 1'b0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      occ = 0;
      tot = 0;
    end else begin
      occ = occ + int'(s_rd_issue) - int'(s_pop);
      if (s_issue) tot++;
    end
  end

  task automatic clear_mon();
    acc_addr_q.delete(); acc_wr_q.delete(); acc_data_q.delete();
    acc_cyc_q.delete();  pop_q.delete();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // rdy_pct < 0 selects the directed stall pattern (rd_ready low 5 cycles).
  task automatic run_burst(input bit wr, input logic [ADDR_LEN-1:0] a, input int len,
                           input int rdy_pct, input int wv_pct, input bit toggle);
    logic [COL_NUM-1:0]  exp_wd [$];
    logic [ADDR_LEN-1:0] ea;
    int sent, d0, budget, n;
    sent = 0;
    clear_mon();
    d0 = done_cnt;
    @(posedge clk); #1;
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = LEN_W'(len);
    bus.wr_valid  = 1'b1;  // must be ignored while idle
    bus.wr_data   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    budget = 0;
    while (done_cnt == d0 && budget < 200) begin
      if (rdy_pct < 0) bus.rd_ready = !(budget >= 2 && budget < 7);
      else             bus.rd_ready = ($urandom_range(99) < rdy_pct);
      if (wr && sent < len && (toggle ? (budget % 2 == 0) : ($urandom_range(99) < wv_pct))) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = {$urandom, $urandom, $urandom, $urandom};
        exp_wd.push_back(bus.wr_data);
        beat_drv = 1'b1;
        sent++;
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = {$urandom, $urandom, $urandom, $urandom};
        beat_drv = 1'b0;
      end
      @(posedge clk); #1;
      budget++;
    end
    beat_drv     = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    chk("done_pulse_seen", done_cnt - d0, 1);
    chk("cmd_ready_after_done", bus.cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_exactly_once", done_cnt - d0, 1);
    chk("access_count", acc_addr_q.size(), len);
    n = (acc_addr_q.size() < len) ? acc_addr_q.size() : len;
    for (int i = 0; i < n; i++) begin
      ea = a + ADDR_LEN'(i);
      chk("access_addr", acc_addr_q[i], ea);
      chk("access_dir", acc_wr_q[i], wr);
      if (wr && i < exp_wd.size()) begin
        chk("write_data", acc_data_q[i], exp_wd[i]);
        ref_mem[ea] = exp_wd[i];
      end
    end
    if (!wr) begin
      chk("read_line_count", pop_q.size(), len);
      n = (pop_q.size() < len) ? pop_q.size() : len;
      for (int i = 0; i < n; i++) begin
        ea = a + ADDR_LEN'(i);
        chk("read_data", pop_q[i], ref_rd(ea));
      end
      if (rdy_pct == 100 && len > 0 && acc_cyc_q.size() == len)
        chk("read_back_to_back", acc_cyc_q[len-1] - acc_cyc_q[0], len - 1);
    end
  endtask

  task automatic reset_mid_burst();
    int d0, budget;
    clear_mon();
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 'h300; bus.cmd_len = 16'd8;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    budget = 0;
    while (acc_addr_q.size() < 3 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("beats_before_reset", acc_addr_q.size() >= 3, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dram_valid", bus.DRAM_valid, 1'b0);
    chk("rst_dram_wr_en", bus.DRAM_wr_en, 1'b0);
    chk("rst_dram_addr", bus.DRAM_addr, '0);
    chk("rst_dram_wr_data", bus.DRAM_wr_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rd_ready = 1'b0;
    clear_mon();
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("no_access_after_abort", acc_addr_q.size(), 0);
    chk("ready_after_abort", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.rd_ready  = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset_rd_valid", bus.rd_valid, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_dram_valid", bus.DRAM_valid, 1'b0);
    chk("reset_wr_ready", bus.wr_ready, 1'b0);
    chk("reset_dram_addr", bus.DRAM_addr, '0);
    rst = 1'b0;

    run_burst(1'b0, 'h10, 4, 100, 0, 1'b0);
    run_burst(1'b0, 'h40, 6, -1, 0, 1'b0);
    run_burst(1'b1, 'h20, 3, 100, 0, 1'b1);
    run_burst(1'b0, 'h20, 3, 100, 0, 1'b0);
    run_burst(1'b0, 25'h1FFFFFE, 4, 100, 0, 1'b0);
    run_burst(1'b0, 'h55, 0, 100, 0, 1'b0);
    run_burst(1'b1, 'h66, 0, 100, 100, 1'b0);
    reset_mid_burst();

`ifdef DRAM_ACC_CNT_EN
    reset_pulse();
    run_burst(1'b0, 'h100, 5, 100, 0, 1'b0);
    run_burst(1'b1, 'h200, 3, 100, 100, 1'b0);
    chk("acc_cnt_read5_write3", acc_cnt, 32'd8);
`endif

    for (int k = 0; k < 30; k++) begin
      logic [ADDR_LEN-1:0] ra;
      ra = ($urandom_range(3) == 0) ? ('1 - ADDR_LEN'($urandom_range(3)))
                                    : ADDR_LEN'($urandom_range(63));
      run_burst(1'($urandom_range(1)), ra, $urandom_range(9),
                $urandom_range(100, 30), $urandom_range(100, 40), 1'b0);
    end

`ifdef DRAM_ACC_CNT_EN
    chk("acc_cnt_total", acc_cnt, 32'(tot));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
